spi_receiver: RTL

//  SPI slave receiver (mode 0, MSB first): the receive end of the SPI link

---
 rtl/spi_receiver_pkg.sv | 10 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_receiver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_receiver_pkg.sv
// Shared definitions for the SPI link: FSM state encodings used by the receiver
// (and by the sender control on the other end of the link).
package spi_receiver_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an async level with single-cycle rise/fall
// detection on the synchronized output; reset value is a parameter.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_in,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              dly;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      sync <= {STAGES{RST_VAL}};
      dly  <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      dly  <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_receiver.sv
// SPI mode-0 slave receiver, MSB first, oversampled on clk. Words go out through
// a one-deep valid/ready holder; overrun and truncated frames raise 1-cycle pulses.
module spi_receiver #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              spi_sck_in,
  input  logic              spi_cs_n_in,
  input  logic              spi_mosi_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              frame_err,
  output logic              busy
);

  import spi_receiver_pkg::*;

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  // cs_n resets to 0 so a chip select already low at reset never looks like a new frame
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .rst_in(rst_in),
    .din   (spi_sck_in),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst_in(rst_in),
    .din   (spi_cs_n_in),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  wire unused_ok = &{1'b0, sck_lvl, sck_fall, cs_lvl};

  always_ff @(posedge clk) begin
    if (rst_in) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              word_done, word_done_nxt;
  logic              frame_err_nxt;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      word_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      word_done <= word_done_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    word_done_nxt = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt   = RECV;
          bit_cnt_nxt = '0;
        end
      end
      RECV: begin
        // cs_n rising takes priority over a coincident sck edge
        if (cs_rise) begin
          state_nxt     = IDLE;
          frame_err_nxt = (bit_cnt != '0);
          bit_cnt_nxt   = '0;
          shreg_nxt     = '0;
        end else if (sck_rise) begin
          shreg_nxt = {shreg[DATA_W-2:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt   = '0;
            word_done_nxt = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full holder being drained this cycle can take the new word in the same cycle
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == RECV);

endmodule
